ifetch_ctrl: RTL and testbench
==============================

# ifetch_ctrl

Instruction-fetch controller between the pipeline datapath's fetch stage and a variable-latency instruction memory. It owns the fetch address register and issues one request at a time over a req/ack handshake. It holds the returned instruction until the datapath consumes it, and it drives the fetch-stage stall. Branch and jump redirects that arrive mid-request are handled by draining the stale response and refetching from the new target.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- TIMEOUT, 64, cycles without ack before `fetch_err` sets (≥1)
- CNT_W, 16, width of the stall counter
- clk, input, 1, sole clock; all state updates on rising edge
- reset, input, 1, synchronous, active-low; reset=0 at a rising edge resets all state
- advance, input, 1, datapath consumes the held instruction this cycle (only meaningful while `instr_valid`=1)
- redirect, input, 1, branch/jump taken (PCSrcD | jump)
- redirect_pc, input, 32, target address; bits [1:0] ignored
- instr, output, 32, held instruction
- instr_pc, output, 32, address of `instr`
- instr_valid, output, 1, `instr` is valid
- stall_f, output, 1, equals !`instr_valid`
- imem_req, output, 1, request to instruction memory
- imem_addr, output, 32, request address; [1:0] always 00
- imem_ack, input, 1, response valid this cycle; sampled only while `imem_req`=1
- imem_rdata, input, 32, response data, valid with `imem_ack`
- fetch_err, output, 1, sticky: a request waited TIMEOUT cycles
- stall_cnt, output, CNT_W, saturating count of cycles with `instr_valid`=0

## Operation
- FSM states and per-state outputs:
  - IDLE: no request.
  - REQ: `imem_req`=1, `imem_addr`=fetch_pc.
  - DROP: `imem_req`=1, `imem_addr`=old fetch_pc; the response will be discarded.
  - HOLD: `instr_valid`=1.
- Reset sets state IDLE, fetch_pc=RESET_PC, pend_pc=0, instr=0, instr_pc=0, instr_valid=0, fetch_err=0, stall_cnt=0, timeout counter=0. During reset `imem_req`=0 and `stall_f`=1.
- IDLE → REQ unconditionally on the first cycle after reset deasserts. `redirect` in IDLE loads fetch_pc.
- REQ:
  - ack & !redirect: capture instr=imem_rdata and instr_pc=fetch_pc, go to HOLD.
  - ack & redirect: discard the data, fetch_pc=redirect_pc, stay in REQ (new address next cycle).
  - !ack & redirect: pend_pc=redirect_pc, go to DROP.
- DROP:
  - ack: discard the data, fetch_pc=pend_pc, go to REQ.
  - redirect (with or without ack): the new redirect_pc overrides pend_pc. With ack, fetch_pc takes the newest target.
- HOLD:
  - redirect has priority over advance: instr_valid=0, fetch_pc=redirect_pc, go to REQ.
  - advance & !redirect: fetch_pc=fetch_pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), go to REQ.
  - Neither: hold all outputs.
- `imem_addr` must not change while `imem_req`=1 and no ack has been seen. This is why DROP exists.
- Timeout counter:
  - Increments each REQ/DROP cycle without ack. Clears on ack and on leaving REQ/DROP; does not clear on the REQ → DROP transition.
  - On reaching TIMEOUT, fetch_err=1 (sticky until reset). The request continues and the counter saturates.
- `stall_cnt` increments every non-reset cycle with `instr_valid`=0 and saturates at all-ones.

## Timing
- `instr`, `instr_pc`, `instr_valid`, `fetch_err` and `stall_cnt` are all registered.
- `imem_req` and `imem_addr` are decoded from state and registers only. There is no combinational path from `imem_ack` to `imem_req`.
- Zero-wait memory (ack in the same cycle as req): the instruction is valid the next cycle. Sustained throughput is 1 instruction per 2 cycles (HOLD+advance → REQ → HOLD).
- Memory with N wait cycles: `instr_valid` rises N+1 cycles after req first asserts.
- Redirect-to-request latency:
  - From HOLD or REQ: 1 cycle.
  - From DROP: 1 cycle after the stale ack.
- A stale instruction is never presented after a redirect.

## Structure
- Package `ifetch_pkg` holds:
  - `ifetch_state_t` enum {IDLE, REQ, DROP, HOLD}.
  - The `INSTR_W`=32 constant.
  - The default RESET_PC constant.
- Sub-module `sat_counter` (parameterised width, inc, clr, saturating) is used for both the timeout counter and `stall_cnt`.
- All registers live in one `always_ff` with synchronous active-low reset. Next-state logic lives in `always_comb`.

## Test plan
- Reset release, zero-wait memory returning 32'h2002_0005 → `imem_addr`=0 one cycle after reset. `instr_valid` and `instr_pc`=0 on the next cycle. `stall_cnt`=2.
- 3-wait-cycle memory, advance held high, 4 fetches → addresses 0,4,8,C in order. Each has `instr_valid` 4 cycles after its req. `imem_addr` stays stable during waits.
- Redirect to 32'h0000_0040 on the second wait cycle of a request to 0x8 → DROP, 0x8 held until ack, data discarded, next req at 0x40. `instr_pc`=0x40 when valid.
- Redirect 0x100 in HOLD with advance=1 in the same cycle → next req at 0x100, not +4. Then a double redirect in DROP (0x200 then 0x300) → next req at 0x300.
- Ack withheld 64 cycles → `fetch_err` rises on cycle 64 and stays set after a later ack. Reset asserted mid-request → `imem_req`=0 and all outputs at reset values the next cycle.
- fetch_pc=32'hFFFF_FFFC plus advance → next request at 0x0.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package ifetch_pkg;

  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch controller state.
  //   IDLE : no request outstanding
  //   REQ  : request at fetch_pc, response will be kept
  //   DROP : request at the old fetch_pc, response will be thrown away
  //   HOLD : instruction held for the datapath
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } ifetch_state_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
    return addr & ~INSTR_W'(3);
  endfunction

endpackage

// File: rtl/ifetch_ctrl_sat_counter.sv
// Saturating up-counter next-value logic. The register itself lives in the
// instantiating module so that all state shares one clocked block.
module sat_counter #(
  parameter int unsigned   W   = 8,
  parameter logic [W-1:0]  MAX = '1
) (
  input  logic [W-1:0] cnt_q,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt_d
);

  // Clear wins over increment; increment stops at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, runs a one-outstanding
// req/ack handshake to instruction memory, holds the returned instruction
// until the datapath advances, and drains stale responses after redirects.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned        TIMEOUT  = 64,
  parameter int unsigned        CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               advance,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirect_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] instr_pc,
  output logic               instr_valid,
  output logic               stall_f,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               fetch_err,
  output logic [CNT_W-1:0]   stall_cnt
);

  // Timeout counter just wide enough to reach TIMEOUT and stop there.
  localparam int unsigned       TO_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]   TO_MAX = TO_W'(TIMEOUT);

  ifetch_state_t      state_q,       state_d;
  logic [INSTR_W-1:0] fetch_pc_q,    fetch_pc_d;
  logic [INSTR_W-1:0] pend_pc_q,     pend_pc_d;
  logic [INSTR_W-1:0] instr_q,       instr_d;
  logic [INSTR_W-1:0] instr_pc_q,    instr_pc_d;
  logic               instr_valid_q, instr_valid_d;
  logic               fetch_err_q,   fetch_err_d;
  logic [CNT_W-1:0]   stall_cnt_q,   stall_cnt_d;
  logic [TO_W-1:0]    to_cnt_q,      to_cnt_d;

  logic               busy;
  logic               ack_seen;
  logic               busy_next;
  logic               to_inc;
  logic               to_clr;
  logic [INSTR_W-1:0] tgt_pc;

  // A request is outstanding in REQ and DROP; ack is ignored elsewhere.
  assign busy     = (state_q == REQ) || (state_q == DROP);
  assign ack_seen = busy && imem_ack;
  assign tgt_pc   = word_align(redirect_pc);

  // Next-state and datapath-register update for the fetch FSM.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    pend_pc_d     = pend_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect) begin
          fetch_pc_d = tgt_pc;
        end
      end

      REQ: begin
        if (ack_seen) begin
          if (redirect) begin
            // Response belongs to the old path: drop it and re-issue at
            // the target next cycle without leaving REQ.
            fetch_pc_d = tgt_pc;
          end else begin
            instr_d       = imem_rdata;
            instr_pc_d    = fetch_pc_q;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
          end
        end else if (redirect) begin
          // The address must stay put until the memory acks, so park the
          // target and wait out the stale response in DROP.
          pend_pc_d = tgt_pc;
          state_d   = DROP;
        end
      end

      DROP: begin
        if (redirect) begin
          pend_pc_d = tgt_pc;
        end
        if (ack_seen) begin
          fetch_pc_d = redirect ? tgt_pc : pend_pc_q;
          state_d    = REQ;
        end
      end

      HOLD: begin
        if (redirect) begin
          instr_valid_d = 1'b0;
          fetch_pc_d    = tgt_pc;
          state_d       = REQ;
        end else if (advance) begin
          instr_valid_d = 1'b0;
          fetch_pc_d    = fetch_pc_q + INSTR_W'(4);
          state_d       = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Timeout counter runs while a request waits; it survives REQ -> DROP.
  assign busy_next = (state_d == REQ) || (state_d == DROP);
  assign to_inc    = busy && !imem_ack;
  assign to_clr    = ack_seen || !busy_next;

  sat_counter #(
    .W   (TO_W),
    .MAX (TO_MAX)
  ) u_timeout_cnt (
    .cnt_q (to_cnt_q),
    .inc   (to_inc),
    .clr   (to_clr),
    .cnt_d (to_cnt_d)
  );

  // Sticky error once any request has waited the full timeout.
  assign fetch_err_d = fetch_err_q || (to_cnt_d == TO_MAX);

  // Stall cycles, saturating at all-ones.
  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .cnt_q (stall_cnt_q),
    .inc   (!instr_valid_q),
    .clr   (1'b0),
    .cnt_d (stall_cnt_d)
  );

  // All controller state, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      fetch_pc_q    <= word_align(RESET_PC);
      pend_pc_q     <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      stall_cnt_q   <= '0;
      to_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      pend_pc_q     <= pend_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
      stall_cnt_q   <= stall_cnt_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  // Request decoded from state only; masked while reset is held so the
  // memory never sees a request in a reset cycle.
  assign imem_req    = busy && reset;
  assign imem_addr   = fetch_pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign stall_f     = !instr_valid_q || !reset;
  assign fetch_err   = fetch_err_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: cycle table plus hand-written reset and
// timeout sequences.
module tb_ifetch_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              advance;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;
  logic              instr_valid;
  logic              stall_f;
  logic              imem_req;
  logic [31:0]       imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              fetch_err;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (TIMEOUT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .advance     (advance),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .stall_f     (stall_f),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .fetch_err   (fetch_err),
    .stall_cnt   (stall_cnt)
  );

  typedef struct {
    logic        adv;
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_ipc;
    logic [31:0] e_instr;
    int          e_scnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic adv, input logic redir, input logic [31:0] rpc,
                              input logic ack, input logic [31:0] rdata,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_vld, input logic [31:0] e_ipc,
                              input logic [31:0] e_instr, input int e_scnt);
    vec_t v;
    v.adv = adv; v.redir = redir; v.rpc = rpc; v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_ipc = e_ipc;
    v.e_instr = e_instr; v.e_scnt = e_scnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic adv, input logic redir,
                       input logic [31:0] rpc, input logic ack, input logic [31:0] rdata);
    reset       = rst_n;
    advance     = adv;
    redirect    = redir;
    redirect_pc = rpc;
    imem_ack    = ack;
    imem_rdata  = rdata;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // One cycle per row: inputs for the cycle, outputs expected in it.
    //              adv redir rpc            ack rdata          req addr           vld ipc            instr          scnt
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0,          0));  // IDLE
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'h2002_0005,  1, 32'h0,          0, 32'h0,          32'h0,          1));  // zero-wait ack
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 32'h0,          32'h2002_0005,  2));
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 32'h0,          32'h2002_0005,  2));  // advance
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,          1, 32'h4,          0, 32'h0,          32'h0,          2));  // 3 waits
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,          1, 32'h4,          0, 32'h0,          32'h0,          3));
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,          1, 32'h4,          0, 32'h0,          32'h0,          4));
    vecs.push_back(mk(1, 0, 32'h0,          1, 32'hA000_0004,  1, 32'h4,          0, 32'h0,          32'h0,          5));
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 32'h4,          32'hA000_0004,  6));
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,          1, 32'h8,          0, 32'h0,          32'h0,          6));  // wait 1
    vecs.push_back(mk(1, 1, 32'h40,         0, 32'h0,          1, 32'h8,          0, 32'h0,          32'h0,          7));  // wait 2 + redirect
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,          1, 32'h8,          0, 32'h0,          32'h0,          8));  // DROP holds 0x8
    vecs.push_back(mk(1, 0, 32'h0,          1, 32'hDEAD_BEEF,  1, 32'h8,          0, 32'h0,          32'h0,          9));  // stale ack
    vecs.push_back(mk(1, 0, 32'h0,          1, 32'hA000_0040,  1, 32'h40,         0, 32'h0,          32'h0,          10));
    vecs.push_back(mk(1, 1, 32'h100,        0, 32'h0,          0, 32'h0,          1, 32'h40,         32'hA000_0040,  11)); // redirect beats advance
    vecs.push_back(mk(0, 1, 32'h200,        0, 32'h0,          1, 32'h100,        0, 32'h0,          32'h0,          11)); // -> DROP
    vecs.push_back(mk(0, 1, 32'h300,        0, 32'h0,          1, 32'h100,        0, 32'h0,          32'h0,          12)); // override pend
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'hBAD0_0100,  1, 32'h100,        0, 32'h0,          32'h0,          13));
    vecs.push_back(mk(0, 1, 32'h400,        1, 32'hBAD0_0300,  1, 32'h300,        0, 32'h0,          32'h0,          14)); // ack+redirect in REQ
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'hA000_0400,  1, 32'h400,        0, 32'h0,          32'h0,          15));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 32'h400,        32'hA000_0400,  15)); // saturated
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFF,  0, 32'h0,          0, 32'h0,          1, 32'h400,        32'hA000_0400,  15)); // low bits dropped
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'hA000_FFFC,  1, 32'hFFFF_FFFC,  0, 32'h0,          32'h0,          15));
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 32'hFFFF_FFFC,  32'hA000_FFFC,  15)); // wrap
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0, 32'h0,          32'h0,          15));

    // Reset state.
    @(negedge clk);
    #1;
    chk("rst.req",       32'(imem_req),    32'd0);
    chk("rst.stall_f",   32'(stall_f),     32'd1);
    chk("rst.vld",       32'(instr_valid), 32'd0);
    chk("rst.err",       32'(fetch_err),   32'd0);
    chk("rst.stall_cnt", 32'(stall_cnt),   32'd0);
    chk("rst.instr",     instr,            32'd0);
    chk("rst.instr_pc",  instr_pc,         32'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(1'b1, vecs[i].adv, vecs[i].redir, vecs[i].rpc, vecs[i].ack, vecs[i].rdata);
      #1;
      chk($sformatf("v%0d.req", i),       32'(imem_req),    32'(vecs[i].e_req));
      if (vecs[i].e_req)
        chk($sformatf("v%0d.addr", i),    imem_addr,        vecs[i].e_addr);
      chk($sformatf("v%0d.vld", i),       32'(instr_valid), 32'(vecs[i].e_vld));
      chk($sformatf("v%0d.stall_f", i),   32'(stall_f),     32'(!vecs[i].e_vld));
      if (vecs[i].e_vld) begin
        chk($sformatf("v%0d.instr_pc", i), instr_pc,        vecs[i].e_ipc);
        chk($sformatf("v%0d.instr", i),    instr,           vecs[i].e_instr);
      end
      chk($sformatf("v%0d.stall_cnt", i), 32'(stall_cnt),   32'(vecs[i].e_scnt));
      chk($sformatf("v%0d.err", i),       32'(fetch_err),   32'd0);
    end

    // Reset asserted while a request to 0x0 is outstanding.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    chk("mrst.req",       32'(imem_req),    32'd0);
    chk("mrst.vld",       32'(instr_valid), 32'd0);
    chk("mrst.stall_f",   32'(stall_f),     32'd1);
    chk("mrst.instr",     instr,            32'd0);
    chk("mrst.instr_pc",  instr_pc,         32'd0);
    chk("mrst.err",       32'(fetch_err),   32'd0);
    chk("mrst.stall_cnt", 32'(stall_cnt),   32'd0);

    // Release; IDLE for one cycle, then ack withheld for TIMEOUT cycles.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("to.idle_req", 32'(imem_req), 32'd0);
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("to.req%0d", k),  32'(imem_req),  32'd1);
      chk($sformatf("to.addr%0d", k), imem_addr,      32'h0);
      chk($sformatf("to.err%0d", k),  32'(fetch_err), 32'd0);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC0DE_0000);
    #1;
    chk("to.err_set",   32'(fetch_err), 32'd1);
    chk("to.req_still", 32'(imem_req),  32'd1);
    chk("to.stall_sat", 32'(stall_cnt), 32'd15);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("to.err_sticky", 32'(fetch_err),   32'd1);
    chk("to.vld",        32'(instr_valid), 32'd1);
    chk("to.instr",      instr,            32'hC0DE_0000);
    chk("to.instr_pc",   instr_pc,         32'h0);

    // Reset clears the sticky error.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    chk("to.err_clr", 32'(fetch_err),   32'd0);
    chk("to.vld_clr", 32'(instr_valid), 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    chk("post.req",  32'(imem_req),  32'd1);
    chk("post.addr", imem_addr,      32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
